// File: rtl/mem_stage_dmem_if.sv
// Bundle between the memory stage, the pipeline around it and the data memory.
// The memory stage is the master: it takes the ex/mem fields plus the memory
// response and drives the dmem request, the stall and the mem/wb fields.
interface mem_stage_dmem_if;
    // ex/mem register fields
    logic        ex_valid;
    logic [6:0]  ex_opcode;
    logic [2:0]  ex_funct3;
    logic [31:0] ex_alu_out;
    logic [31:0] ex_rs2_v;
    // data memory
    logic        dmem_resp;
    logic [31:0] dmem_addr;
    logic [3:0]  dmem_rmask;
    logic [3:0]  dmem_wmask;
    logic [31:0] dmem_wdata;
    // pipeline control and mem/wb register
    logic        freeze_stall;
    logic        wb_valid;
    logic [31:0] wb_dmem_addr;
    logic [3:0]  wb_dmem_rmask;
    logic [3:0]  wb_dmem_wmask;
    logic [31:0] wb_dmem_wdata;
    logic        wb_misaligned;
    logic        dmem_timeout;

    modport master (
        input  ex_valid, ex_opcode, ex_funct3, ex_alu_out, ex_rs2_v, dmem_resp,
        output dmem_addr, dmem_rmask, dmem_wmask, dmem_wdata, freeze_stall,
               wb_valid, wb_dmem_addr, wb_dmem_rmask, wb_dmem_wmask,
               wb_dmem_wdata, wb_misaligned, dmem_timeout
    );

    modport slave (
        output ex_valid, ex_opcode, ex_funct3, ex_alu_out, ex_rs2_v, dmem_resp,
        input  dmem_addr, dmem_rmask, dmem_wmask, dmem_wdata, freeze_stall,
               wb_valid, wb_dmem_addr, wb_dmem_rmask, wb_dmem_wmask,
               wb_dmem_wdata, wb_misaligned, dmem_timeout
    );
endinterface

// File: rtl/mem_stage_dmem.sv
// Memory stage data-memory request initiator for the in-order rv32i pipeline.
// Issues one-cycle load/store requests, stalls the pipeline until the memory
// responds, and registers the per-access fields needed by writeback.
module mem_stage_dmem #(
    parameter int unsigned TIMEOUT_CYCLES = 0
) (
    input  logic             clk,
    input  logic             rst,
    mem_stage_dmem_if.master bus
);

    localparam logic [6:0]  OP_LOAD     = 7'b0000011;
    localparam logic [6:0]  OP_STORE    = 7'b0100011;
    localparam logic [31:0] TIMEOUT_LIM = TIMEOUT_CYCLES;
    localparam logic        TIMEOUT_EN  = (TIMEOUT_CYCLES != 0);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_WAIT = 1'b1
    } state_e;

    // Byte enables for an aligned access of the size encoded in funct3.
    function automatic logic [3:0] mask_f(input logic [2:0] f3, input logic [1:0] a);
        logic [3:0] m;
        case (f3[1:0])
            2'b00:   m = 4'b0001 << a;
            2'b01:   m = 4'b0011 << {a[1], 1'b0};
            2'b10:   m = 4'b1111;
            default: m = 4'b0000;
        endcase
        return m;
    endfunction

    // Store data replicated on every lane so the write mask picks the lane.
    function automatic logic [31:0] wdata_f(input logic [2:0] f3, input logic [31:0] rs2);
        logic [31:0] d;
        case (f3[1:0])
            2'b00:   d = {4{rs2[7:0]}};
            2'b01:   d = {2{rs2[15:0]}};
            2'b10:   d = rs2;
            default: d = 32'h0000_0000;
        endcase
        return d;
    endfunction

    // Natural alignment check; unused funct3 encodings never qualify.
    function automatic logic aligned_f(input logic [2:0] f3, input logic [1:0] a);
        logic ok;
        case (f3)
            3'b000, 3'b100: ok = 1'b1;
            3'b001, 3'b101: ok = ~a[0];
            3'b010:         ok = (a == 2'b00);
            default:        ok = 1'b0;
        endcase
        return ok;
    endfunction

    state_e      state_q;
    logic [31:0] dmem_addr_q;
    logic [3:0]  dmem_rmask_q;
    logic [3:0]  dmem_wmask_q;
    logic [31:0] dmem_wdata_q;
    logic        wb_valid_q;
    logic [31:0] wb_dmem_addr_q;
    logic [3:0]  wb_dmem_rmask_q;
    logic [3:0]  wb_dmem_wmask_q;
    logic [31:0] wb_dmem_wdata_q;
    logic        wb_misaligned_q;
    logic        dmem_timeout_q;
    logic [31:0] wd_cnt_q;

    logic        is_load_s;
    logic        is_store_s;
    logic        mem_op_s;
    logic        misalign_s;
    logic        stall_s;
    logic        accept_s;
    logic [3:0]  rmask_d;
    logic [3:0]  wmask_d;
    logic [31:0] wdata_d;
    logic [31:0] wd_cnt_d;
    logic        timeout_d;

    // Combinational stall: a response in the same cycle releases the pipeline.
    assign stall_s  = (state_q == ST_WAIT) && !bus.dmem_resp;
    assign accept_s = !stall_s;

    // Decode the ex/mem instruction and build the request fields and watchdog next state.
    always_comb begin
        is_load_s  = bus.ex_valid && (bus.ex_opcode == OP_LOAD);
        is_store_s = bus.ex_valid && (bus.ex_opcode == OP_STORE);
        mem_op_s   = 1'b0;
        misalign_s = 1'b0;
        rmask_d    = 4'b0000;
        wmask_d    = 4'b0000;
        wdata_d    = 32'h0000_0000;
        if (is_load_s || is_store_s) begin
            if (aligned_f(bus.ex_funct3, bus.ex_alu_out[1:0])) begin
                mem_op_s = 1'b1;
                if (is_load_s) begin
                    rmask_d = mask_f(bus.ex_funct3, bus.ex_alu_out[1:0]);
                end else begin
                    wmask_d = mask_f(bus.ex_funct3, bus.ex_alu_out[1:0]);
                    wdata_d = wdata_f(bus.ex_funct3, bus.ex_rs2_v);
                end
            end else begin
                misalign_s = 1'b1;
            end
        end else begin
            mem_op_s   = 1'b0;
        end

        // Count stalled WAIT cycles, saturating at the limit (stays 0 when disabled).
        wd_cnt_d = 32'd0;
        if (stall_s) begin
            if (wd_cnt_q != TIMEOUT_LIM) begin
                wd_cnt_d = wd_cnt_q + 32'd1;
            end else begin
                wd_cnt_d = wd_cnt_q;
            end
        end else begin
            wd_cnt_d = 32'd0;
        end
        timeout_d = dmem_timeout_q || (TIMEOUT_EN && (wd_cnt_d == TIMEOUT_LIM));
    end

    // Request FSM, mem/wb register and watchdog state.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q         <= ST_IDLE;
            dmem_addr_q     <= 32'h0000_0000;
            dmem_rmask_q    <= 4'b0000;
            dmem_wmask_q    <= 4'b0000;
            dmem_wdata_q    <= 32'h0000_0000;
            wb_valid_q      <= 1'b0;
            wb_dmem_addr_q  <= 32'h0000_0000;
            wb_dmem_rmask_q <= 4'b0000;
            wb_dmem_wmask_q <= 4'b0000;
            wb_dmem_wdata_q <= 32'h0000_0000;
            wb_misaligned_q <= 1'b0;
            dmem_timeout_q  <= 1'b0;
            wd_cnt_q        <= 32'd0;
        end else begin
            wd_cnt_q       <= wd_cnt_d;
            dmem_timeout_q <= timeout_d;
            if (accept_s) begin
                wb_valid_q      <= bus.ex_valid;
                wb_dmem_addr_q  <= bus.ex_alu_out;
                wb_misaligned_q <= misalign_s;
                wb_dmem_rmask_q <= rmask_d;
                wb_dmem_wmask_q <= wmask_d;
                wb_dmem_wdata_q <= wdata_d;
                dmem_rmask_q    <= rmask_d;
                dmem_wmask_q    <= wmask_d;
                if (mem_op_s) begin
                    dmem_addr_q  <= {bus.ex_alu_out[31:2], 2'b00};
                    dmem_wdata_q <= wdata_d;
                    state_q      <= ST_WAIT;
                end else begin
                    state_q      <= ST_IDLE;
                end
            end else begin
                // Still waiting: the request pulse is over, everything else holds.
                dmem_rmask_q <= 4'b0000;
                dmem_wmask_q <= 4'b0000;
                state_q      <= ST_WAIT;
            end
        end
    end

    assign bus.freeze_stall  = stall_s;
    assign bus.dmem_addr     = dmem_addr_q;
    assign bus.dmem_rmask    = dmem_rmask_q;
    assign bus.dmem_wmask    = dmem_wmask_q;
    assign bus.dmem_wdata    = dmem_wdata_q;
    assign bus.wb_valid      = wb_valid_q;
    assign bus.wb_dmem_addr  = wb_dmem_addr_q;
    assign bus.wb_dmem_rmask = wb_dmem_rmask_q;
    assign bus.wb_dmem_wmask = wb_dmem_wmask_q;
    assign bus.wb_dmem_wdata = wb_dmem_wdata_q;
    assign bus.wb_misaligned = wb_misaligned_q;
    assign bus.dmem_timeout  = dmem_timeout_q;

endmodule

// File: tb/tb_mem_stage_dmem.sv
// Self-checking bench for mem_stage_dmem: directed cases plus randomized
// instruction streams compared against a size/alignment reference model.
module tb_mem_stage_dmem;

    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_pass;

    logic        pending;     // DUT is waiting and the next instruction brings the response
    logic [31:0] last_addr;   // last issued word address

    mem_stage_dmem_if dif ();

    mem_stage_dmem #(.TIMEOUT_CYCLES(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (dif)
    );

    // Free-running clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Single comparison point for every check in the bench.
    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Present one instruction, check its mem/wb result and any stall it causes.
    task automatic run_instr(input logic v, input logic [6:0] opc, input logic [2:0] f3,
                             input logic [31:0] addr, input logic [31:0] rs2, input int lat);
        int          n;
        logic        is_mem;
        logic        is_ld;
        logic        ok;
        logic        memop;
        logic [3:0]  m;
        logic [31:0] wd;
        is_mem = v && (opc == OP_LOAD || opc == OP_STORE);
        is_ld  = (opc == OP_LOAD);
        n      = 1 << f3[1:0];
        ok     = (f3 != 3'd3) && (f3 != 3'd6) && (f3 != 3'd7) && ((addr % n) == 0);
        memop  = is_mem && ok;
        m      = memop ? 4'(((1 << n) - 1) << (addr % 4)) : 4'b0000;
        wd     = 32'h0;
        for (int i = 0; i < 4; i++) wd[8*i +: 8] = rs2[8*(i % n) +: 8];

        dif.ex_valid   = v;
        dif.ex_opcode  = opc;
        dif.ex_funct3  = f3;
        dif.ex_alu_out = addr;
        dif.ex_rs2_v   = rs2;
        dif.dmem_resp  = pending ? 1'b1 : ($urandom_range(0, 3) == 0);
        #1;
        check_eq("stall_at_accept", dif.freeze_stall, 1'b0);
        @(posedge clk); #1;
        dif.dmem_resp = 1'b0;
        if (memop) last_addr = {addr[31:2], 2'b00};
        check_eq("wb_valid", dif.wb_valid, v);
        check_eq("wb_addr", dif.wb_dmem_addr, addr);
        check_eq("wb_misaligned", dif.wb_misaligned, is_mem && !ok);
        check_eq("wb_rmask", dif.wb_dmem_rmask, is_ld ? m : 4'b0000);
        check_eq("wb_wmask", dif.wb_dmem_wmask, is_ld ? 4'b0000 : m);
        check_eq("dmem_rmask", dif.dmem_rmask, is_ld ? m : 4'b0000);
        check_eq("dmem_wmask", dif.dmem_wmask, is_ld ? 4'b0000 : m);
        check_eq("dmem_addr", dif.dmem_addr, last_addr);
        if (memop && !is_ld) begin
            check_eq("dmem_wdata", dif.dmem_wdata, wd);
            check_eq("wb_wdata", dif.wb_dmem_wdata, wd);
        end
        check_eq("timeout_idle", dif.dmem_timeout, 1'b0);
        if (memop) begin
            for (int k = 0; k < lat; k++) begin
                dif.ex_valid   = 1'b1;
                dif.ex_opcode  = ($urandom_range(0, 1) == 0) ? OP_LOAD : OP_STORE;
                dif.ex_funct3  = 3'($urandom);
                dif.ex_alu_out = $urandom;
                dif.ex_rs2_v   = $urandom;
                #1;
                check_eq("stall_wait", dif.freeze_stall, 1'b1);
                check_eq("wb_addr_hold", dif.wb_dmem_addr, addr);
                check_eq("rmask_pulse", dif.dmem_rmask, (k == 0 && is_ld) ? m : 4'b0000);
                check_eq("wmask_pulse", dif.dmem_wmask, (k == 0 && !is_ld) ? m : 4'b0000);
                @(posedge clk); #1;
            end
            pending = 1'b1;
        end else begin
            pending = 1'b0;
        end
    endtask

    // Stimulus and checking sequence.
    initial begin
        n_checks = 0;
        n_pass = 0;
        pending = 1'b0;
        last_addr = 32'h0;
        rst = 1'b0;
        dif.ex_valid = 1'b0;
        dif.ex_opcode = 7'h00;
        dif.ex_funct3 = 3'd0;
        dif.ex_alu_out = 32'h0;
        dif.ex_rs2_v = 32'h0;
        dif.dmem_resp = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_eq("rst_stall", dif.freeze_stall, 1'b0);
        check_eq("rst_rmask", dif.dmem_rmask, 4'b0000);
        check_eq("rst_wmask", dif.dmem_wmask, 4'b0000);
        check_eq("rst_addr", dif.dmem_addr, 32'h0);
        check_eq("rst_wb_valid", dif.wb_valid, 1'b0);
        check_eq("rst_timeout", dif.dmem_timeout, 1'b0);
        rst = 1'b1;

        // Directed cases.
        run_instr(1'b1, OP_LOAD,  3'b010, 32'h1000_0008, 32'h0, 3);
        run_instr(1'b1, OP_STORE, 3'b000, 32'h2000_0003, 32'hAABB_CCDD, 1);
        run_instr(1'b1, OP_STORE, 3'b001, 32'h2000_0002, 32'hAABB_CCDD, 0);
        run_instr(1'b1, OP_LOAD,  3'b001, 32'h3000_0001, 32'h0, 0);
        run_instr(1'b1, OP_LOAD,  3'b010, 32'h3000_0002, 32'h0, 0);
        run_instr(1'b1, OP_LOAD,  3'b010, 32'h4000_0010, 32'h0, 0);
        run_instr(1'b1, OP_LOAD,  3'b010, 32'h4000_0014, 32'h0, 0);
        run_instr(1'b1, 7'h33,    3'b000, 32'h5555_0001, 32'h1234_5678, 0);

        // Randomized stream.
        for (int i = 0; i < 300; i++) begin
            logic [6:0]  opc;
            logic [31:0] a;
            case ($urandom_range(0, 5))
                0, 1:    opc = OP_LOAD;
                2, 3:    opc = OP_STORE;
                4:       opc = 7'h33;
                default: opc = 7'($urandom);
            endcase
            a = $urandom;
            if ($urandom_range(0, 1) == 0) a[1:0] = 2'b00;
            run_instr($urandom_range(0, 7) != 0, opc, 3'($urandom), a, $urandom,
                      $urandom_range(0, 3));
        end
        run_instr(1'b0, 7'h00, 3'd0, 32'h0, 32'h0, 0);

        // Reset while waiting, then a late response.
        run_instr(1'b1, OP_LOAD, 3'b010, 32'h6000_0020, 32'h0, 2);
        rst = 1'b0;
        dif.ex_valid = 1'b0;
        dif.ex_alu_out = 32'h0;
        @(posedge clk); #1;
        check_eq("midrst_stall", dif.freeze_stall, 1'b0);
        check_eq("midrst_addr", dif.dmem_addr, 32'h0);
        check_eq("midrst_wb_valid", dif.wb_valid, 1'b0);
        rst = 1'b1;
        dif.dmem_resp = 1'b1;
        #1;
        check_eq("late_resp_stall", dif.freeze_stall, 1'b0);
        @(posedge clk); #1;
        dif.dmem_resp = 1'b0;
        check_eq("late_resp_rmask", dif.dmem_rmask, 4'b0000);
        check_eq("late_resp_valid", dif.wb_valid, 1'b0);
        check_eq("late_resp_stall2", dif.freeze_stall, 1'b0);
        pending = 1'b0;
        last_addr = 32'h0;

        // Watchdog: no response for a while, sticky after the response.
        dif.ex_valid = 1'b1;
        dif.ex_opcode = OP_LOAD;
        dif.ex_funct3 = 3'b010;
        dif.ex_alu_out = 32'h7000_0040;
        for (int k = 1; k <= 7; k++) begin
            @(posedge clk); #1;
            dif.ex_valid = 1'b0;
            check_eq("timeout_ramp", dif.dmem_timeout, k >= 5);
            check_eq("timeout_stall", dif.freeze_stall, 1'b1);
        end
        dif.dmem_resp = 1'b1;
        #1;
        check_eq("timeout_release", dif.freeze_stall, 1'b0);
        @(posedge clk); #1;
        dif.dmem_resp = 1'b0;
        check_eq("timeout_sticky", dif.dmem_timeout, 1'b1);
        check_eq("timeout_idle_stall", dif.freeze_stall, 1'b0);
        rst = 1'b0;
        @(posedge clk); #1;
        check_eq("timeout_cleared", dif.dmem_timeout, 1'b0);
        rst = 1'b1;

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
